// File: rtl/machine_pkg.sv
// Shared types and default geometry for the message display path
// (converter and scroller top levels both pull their defaults from here).
package machine_pkg;
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'h00;

  localparam int unsigned DEF_DIGITS      = 4;
  localparam int unsigned DEF_REFRESH_DIV = 50000;
  localparam int unsigned DEF_SCROLL_DIV  = 25000000;

  function automatic seg_t seg_drive(input seg_t s, input bit active_low);
    return active_low ? ~s : s;
  endfunction
endpackage

// File: rtl/machine_tick_div.sv
// Free-running divider: one-cycle pulse on the last count of every DIV cycles.
module machine_tick_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/machine_seg_scroller.sv
// Scrolls accepted segment patterns right-to-left across a multiplexed
// seven-segment display; one pending byte is held until the next scroll step.
module machine_seg_scroller
  import machine_pkg::*;
#(
  parameter int unsigned DIGITS         = DEF_DIGITS,
  parameter int unsigned REFRESH_DIV    = DEF_REFRESH_DIV,
  parameter int unsigned SCROLL_DIV     = DEF_SCROLL_DIV,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic [7:0]        seg_in,
  input  logic              seg_valid,
  output logic              seg_ready,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] an_out
);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  seg_t            disp_buf [DIGITS];
  seg_t            pend;
  logic            pend_v;
  logic [IW-1:0]   dig_idx;
  logic            scroll_tick;
  logic            ref_tick;
  logic            accept;
  logic [DIGITS-1:0] an_hot;

  machine_tick_div #(.DIV(SCROLL_DIV)) scroll_div (
    .clk  (system1000),
    .rst  (system1000_rst),
    .tick (scroll_tick)
  );

  machine_tick_div #(.DIV(REFRESH_DIV)) refresh_div (
    .clk  (system1000),
    .rst  (system1000_rst),
    .tick (ref_tick)
  );

  assign seg_ready = ~pend_v;
  assign accept    = seg_valid & ~pend_v;

  // A tick and an accept can coincide only with pend_v=0: blank shifts in,
  // the new byte waits in pend for the following tick.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      for (int unsigned i = 0; i < DIGITS; i++)
        disp_buf[i] <= SEG_BLANK;
      pend   <= SEG_BLANK;
      pend_v <= 1'b0;
    end else begin
      if (scroll_tick) begin
        for (int unsigned i = 1; i < DIGITS; i++)
          disp_buf[i] <= disp_buf[i-1];
        disp_buf[0] <= pend_v ? pend : SEG_BLANK;
      end
      if (accept) begin
        pend   <= seg_in;
        pend_v <= 1'b1;
      end else if (scroll_tick) begin
        pend_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst)
      dig_idx <= '0;
    else if (ref_tick)
      dig_idx <= (dig_idx == IW'(DIGITS - 1)) ? '0 : dig_idx + IW'(1);
  end

  always_comb begin
    an_hot          = '0;
    an_hot[dig_idx] = 1'b1;
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      seg_out <= seg_drive(SEG_BLANK, SEG_ACTIVE_LOW);
      an_out  <= SEG_ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);
    end else begin
      seg_out <= seg_drive(disp_buf[dig_idx], SEG_ACTIVE_LOW);
      an_out  <= SEG_ACTIVE_LOW ? ~an_hot : an_hot;
    end
  end
endmodule
